// File: rtl/timer_counter_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : timer_counter_engine_if
//  Description : Command/status bundle between the setting logic (master),
//                the BCD count engine (slave) and the display/alarm logic.
//  Revision    : 1.0 - initial release
// ============================================================================
interface timer_counter_engine_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] load_digits;
  logic                    start;
  logic                    pause;
  logic                    clear;
  logic                    count_up;
  logic [4*NUM_DIGITS-1:0] digits;
  logic                    is_zero;
  logic                    running;
  logic                    paused;
  logic                    expired;
  logic                    done_pulse;
  logic                    tick;

  // Command source side: issues commands, observes the count.
  modport master (
    output load, load_digits, start, pause, clear, count_up,
    input  digits, is_zero, running, paused, expired, done_pulse, tick
  );

  // Count engine side.
  modport slave (
    input  load, load_digits, start, pause, clear, count_up,
    output digits, is_zero, running, paused, expired, done_pulse, tick
  );
endinterface
`default_nettype wire

// File: rtl/timer_counter_engine.sv
`default_nettype none
// ============================================================================
//  Module      : timer_counter_engine
//  Description : N-digit BCD up/down count engine with tick prescaler,
//                pause/resume, clear, saturating load and expiry signalling.
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_counter_engine #(
  parameter int NUM_DIGITS  = 4,
  parameter int TICK_DIV    = 25000000,
  parameter int SEXAGESIMAL = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  timer_counter_engine_if.slave         bus
);

  // Prescaler width; TICK_DIV is at least 2 so this is never zero.
  localparam int               PW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]    C_TICK_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  state_t                       state_q, state_d;
  logic [NUM_DIGITS-1:0][3:0]   digits_q, digits_d;
  logic [PW-1:0]                presc_q, presc_d;
  logic                         dir_up_q, dir_up_d;
  logic                         done_q, done_d;

  logic [NUM_DIGITS-1:0][3:0]   w_max;
  logic [NUM_DIGITS-1:0][3:0]   w_load_sat;
  logic [NUM_DIGITS-1:0][3:0]   w_dec;
  logic [NUM_DIGITS-1:0][3:0]   w_inc;
  logic                         w_borrow;
  logic                         w_carry;
  logic                         w_tick;
  logic                         w_is_zero;
  logic                         w_full;
  logic                         w_dec_zero;
  logic                         w_inc_full;

  // Per-digit limit and load saturation (odd digits are tens of min/sec
  // in sexagesimal mode and top out at 5).
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      localparam logic [3:0] C_MAX = ((SEXAGESIMAL != 0) && ((gi % 2) == 1)) ? 4'd5 : 4'd9;
      assign w_max[gi]      = C_MAX;
      assign w_load_sat[gi] = (bus.load_digits[4*gi +: 4] > C_MAX) ? C_MAX
                                                                   : bus.load_digits[4*gi +: 4];
    end
  endgenerate

  assign w_tick     = (presc_q == C_TICK_LAST);
  assign w_is_zero  = (digits_q == '0);
  assign w_full     = (digits_q == w_max);
  assign w_dec_zero = (w_dec == '0);
  assign w_inc_full = (w_inc == w_max);

  // Ripple borrow/carry chains, one 4-bit BCD digit at a time.
  always_comb begin
    w_dec    = digits_q;
    w_inc    = digits_q;
    w_borrow = 1'b1;
    w_carry  = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_borrow) begin
        if (digits_q[i] == 4'd0) begin
          w_dec[i] = w_max[i];
        end else begin
          w_dec[i] = digits_q[i] - 4'd1;
          w_borrow = 1'b0;
        end
      end
      if (w_carry) begin
        if (digits_q[i] >= w_max[i]) begin
          w_inc[i] = 4'd0;
        end else begin
          w_inc[i] = digits_q[i] + 4'd1;
          w_carry  = 1'b0;
        end
      end
    end
  end

  // Next-state logic: clear > load > pause > start > tick.
  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    dir_up_d = dir_up_q;
    presc_d  = w_tick ? '0 : presc_q + PW'(1);

    if (bus.clear) begin
      state_d  = ST_IDLE;
      digits_d = '0;
      presc_d  = '0;
    end else if (bus.load && (state_q != ST_RUNNING)) begin
      state_d  = ST_IDLE;
      digits_d = w_load_sat;
      presc_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            dir_up_d = bus.count_up;
            presc_d  = '0;
            // A down count from zero has nothing to do.
            if (bus.count_up || !w_is_zero) begin
              state_d = ST_RUNNING;
            end
          end
        end
        ST_RUNNING: begin
          if (bus.pause) begin
            state_d = ST_PAUSED;
          end else if (w_tick) begin
            if (dir_up_q) begin
              if (w_full) begin
                state_d = ST_EXPIRED;
              end else begin
                digits_d = w_inc;
                if (w_inc_full) begin
                  state_d = ST_EXPIRED;
                end
              end
            end else begin
              if (w_is_zero) begin
                state_d = ST_EXPIRED;
              end else begin
                digits_d = w_dec;
                if (w_dec_zero) begin
                  state_d = ST_EXPIRED;
                end
              end
            end
          end
        end
        ST_PAUSED: begin
          // Prescaler keeps its phase across a resume.
          if (bus.start) begin
            state_d = ST_RUNNING;
          end
        end
        ST_EXPIRED: begin
          state_d = ST_EXPIRED;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    done_d = (state_d == ST_EXPIRED) && (state_q != ST_EXPIRED);
  end

  // State, digit, prescaler and direction registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      digits_q <= '0;
      presc_q  <= '0;
      dir_up_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      presc_q  <= presc_d;
      dir_up_q <= dir_up_d;
      done_q   <= done_d;
    end
  end

  assign bus.digits     = digits_q;
  assign bus.is_zero    = w_is_zero;
  assign bus.running    = (state_q == ST_RUNNING);
  assign bus.paused     = (state_q == ST_PAUSED);
  assign bus.expired    = (state_q == ST_EXPIRED);
  assign bus.done_pulse = done_q;
  assign bus.tick       = w_tick;

endmodule
`default_nettype wire
